// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronized A/B phases -> step/up_down strobes and a wrapping position count.
// Optional glitch filter per phase when QUAD_FILTER_EN is defined.
module quad_decoder #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             enable,
  output logic             step,
  output logic             up_down,
  output logic [WIDTH-1:0] position,
  output logic             wrap,
  output logic             err
);

  localparam int unsigned SETTLE_W = 5;
`ifdef QUAD_FILTER_EN
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SETTLE_CYC = 3 + FILT_LEN;
`else
  localparam int unsigned SETTLE_CYC = 3;
`endif
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYC);
  localparam logic [WIDTH-1:0]    POS_MAX     = '1;

  if ((FILT_LEN < 2) || (FILT_LEN > 15)) begin : g_filt_range
    $error("quad_decoder: FILT_LEN must be within 2..15");
  end

  logic [1:0] sync_a_q, sync_b_q;
  logic       lvl_a, lvl_b;

`ifdef QUAD_FILTER_EN
  logic             filt_a_q, filt_b_q, filt_a_d, filt_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_a_d, cnt_b_d;

  // Filtered level flips only after FILT_LEN consecutive disagreeing samples
  always_comb begin
    filt_a_d = filt_a_q;
    cnt_a_d  = '0;
    filt_b_d = filt_b_q;
    cnt_b_d  = '0;
    if (sync_a_q[1] != filt_a_q) begin
      if (cnt_a_q == CNT_W'(FILT_LEN - 1)) filt_a_d = sync_a_q[1];
      else                                 cnt_a_d  = cnt_a_q + CNT_W'(1);
    end
    if (sync_b_q[1] != filt_b_q) begin
      if (cnt_b_q == CNT_W'(FILT_LEN - 1)) filt_b_d = sync_b_q[1];
      else                                 cnt_b_d  = cnt_b_q + CNT_W'(1);
    end
  end

  assign lvl_a = filt_a_q;
  assign lvl_b = filt_b_q;
`else
  assign lvl_a = sync_a_q[1];
  assign lvl_b = sync_b_q[1];
`endif

  logic [1:0]          cur_s, prev_q, idx_cur, idx_prev, delta;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [WIDTH-1:0]    pos_q, pos_d;
  logic                step_q, step_d, wrap_q, wrap_d;
  logic                up_down_q, up_down_d, err_q, err_d;

  // Gray {A,B} -> cycle index; index difference 1 = up, 3 = down, 2 = illegal
  assign cur_s    = {lvl_a, lvl_b};
  assign idx_cur  = {cur_s[0], cur_s[1] ^ cur_s[0]};
  assign idx_prev = {prev_q[0], prev_q[1] ^ prev_q[0]};
  assign delta    = idx_cur - idx_prev;

  always_comb begin
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    up_down_d = up_down_q;
    pos_d     = pos_q;
    err_d     = err_q;
    settle_d  = settle_q;
    if (settle_q != '0) begin
      settle_d = settle_q - SETTLE_W'(1);
    end else begin
      case (delta)
        2'd1: if (enable) begin
          step_d    = 1'b1;
          up_down_d = 1'b1;
          pos_d     = pos_q + WIDTH'(1);
          wrap_d    = (pos_q == POS_MAX);
        end
        2'd3: if (enable) begin
          step_d    = 1'b1;
          up_down_d = 1'b0;
          pos_d     = pos_q - WIDTH'(1);
          wrap_d    = (pos_q == '0);
        end
        2'd2:    err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_q  <= '0;
      sync_b_q  <= '0;
      prev_q    <= '0;
      settle_q  <= SETTLE_INIT;
      pos_q     <= '0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
      up_down_q <= 1'b1;
      err_q     <= 1'b0;
`ifdef QUAD_FILTER_EN
      filt_a_q  <= 1'b0;
      filt_b_q  <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
`endif
    end else begin
      sync_a_q  <= {sync_a_q[0], quad_a};
      sync_b_q  <= {sync_b_q[0], quad_b};
      prev_q    <= cur_s;
      settle_q  <= settle_d;
      pos_q     <= pos_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
      up_down_q <= up_down_d;
      err_q     <= err_d;
`ifdef QUAD_FILTER_EN
      filt_a_q  <= filt_a_d;
      filt_b_q  <= filt_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
`endif
    end
  end

  assign step     = step_q;
  assign wrap     = wrap_q;
  assign up_down  = up_down_q;
  assign position = pos_q;
  assign err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed encoder sequences plus a random walk,
// every cycle compared against a behavioural model of the decoder rules.
module tb_quad_decoder;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned FILT_LEN = 3;
`ifdef QUAD_FILTER_EN
  localparam int SETTLE = 3 + FILT_LEN;
`else
  localparam int SETTLE = 3;
`endif
  localparam int MOD = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             quad_a = 1'b0;
  logic             quad_b = 1'b0;
  logic             enable = 1'b1;
  logic             step, up_down, wrap, err;
  logic [WIDTH-1:0] position;

  quad_decoder #(.WIDTH(WIDTH), .FILT_LEN(FILT_LEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .enable   (enable),
    .step     (step),
    .up_down  (up_down),
    .position (position),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pins pass through two sampling stages, then the decoder rules
  bit [1:0] pipe[$];
  bit [1:0] m_prev;
  bit [1:0] up_order[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int       m_settle;
  int       m_pos;
  bit       m_step, m_wrap, m_ud, m_err;
`ifdef QUAD_FILTER_EN
  bit [1:0] m_filt;
  int       m_run[2];
`endif

  function automatic int order_of(input bit [1:0] s);
    for (int i = 0; i < 4; i++) if (up_order[i] == s) return i;
    return 0;
  endfunction

  task automatic model_edge();
    bit [1:0] synced, cur;
    int d;
    if (reset) begin
      pipe.delete();
      pipe.push_back(2'b00);
      pipe.push_back(2'b00);
      m_prev = 2'b00; m_settle = SETTLE; m_pos = 0;
      m_step = 0; m_wrap = 0; m_ud = 1; m_err = 0;
`ifdef QUAD_FILTER_EN
      m_filt = 2'b00; m_run[0] = 0; m_run[1] = 0;
`endif
      return;
    end
    synced = pipe.pop_front();
    pipe.push_back({quad_a, quad_b});
`ifdef QUAD_FILTER_EN
    cur = m_filt;
    for (int k = 0; k < 2; k++) begin
      if (synced[k] != m_filt[k]) begin
        m_run[k]++;
        if (m_run[k] == FILT_LEN) begin
          m_filt[k] = synced[k];
          m_run[k] = 0;
        end
      end else m_run[k] = 0;
    end
`else
    cur = synced;
`endif
    m_step = 0;
    m_wrap = 0;
    if (m_settle > 0) m_settle--;
    else begin
      d = (order_of(cur) - order_of(m_prev) + 4) % 4;
      if (d == 2) m_err = 1;
      else if (d != 0 && enable) begin
        m_step = 1;
        m_ud   = (d == 1);
        if (d == 1) begin
          m_wrap = (m_pos == MOD - 1);
          m_pos  = (m_pos + 1) % MOD;
        end else begin
          m_wrap = (m_pos == 0);
          m_pos  = (m_pos + MOD - 1) % MOD;
        end
      end
    end
    m_prev = cur;
  endtask

  // Apply pins for n cycles, checking every output after each edge
  task automatic drive(input bit [1:0] ab, input bit en, input bit rst, input int n);
    repeat (n) begin
      @(negedge clk);
      {quad_a, quad_b} = ab;
      enable = en;
      reset  = rst;
      @(posedge clk);
      model_edge();
      #1;
      check("step", 32'(step), 32'(m_step));
      check("wrap", 32'(wrap), 32'(m_wrap));
      check("up_down", 32'(up_down), 32'(m_ud));
      check("position", 32'(position), 32'(m_pos));
      check("err", 32'(err), 32'(m_err));
    end
  endtask

  int g;
  int r;

  initial begin
    drive(2'b00, 1, 1, 2);
    drive(2'b00, 1, 0, SETTLE + 2);
    // Up through one full cycle: 0 -> 4
    drive(2'b10, 1, 0, 4);
    drive(2'b11, 1, 0, 4);
    drive(2'b01, 1, 0, 4);
    drive(2'b00, 1, 0, 4);
    check("pos_after_up", 32'(position), 32'd4);
    // Six down steps: 4 -> 14 through the 0 -> 15 wrap
    drive(2'b01, 1, 0, 4);
    drive(2'b11, 1, 0, 4);
    drive(2'b10, 1, 0, 4);
    drive(2'b00, 1, 0, 4);
    drive(2'b01, 1, 0, 4);
    drive(2'b11, 1, 0, 4);
    check("pos_after_down", 32'(position), 32'd14);
    // Counting frozen while disabled, no step on re-enable
    drive(2'b01, 0, 0, 4);
    drive(2'b00, 0, 0, 4);
    drive(2'b10, 0, 0, 4);
    drive(2'b10, 1, 0, 6);
    check("pos_after_disable", 32'(position), 32'd14);
    // Up to 15, then the 15 -> 0 wrap
    drive(2'b11, 1, 0, 4);
    drive(2'b01, 1, 0, 4);
    check("pos_after_wrap_up", 32'(position), 32'd0);
    // Illegal both-phase jump, then legal counting with err held
    drive(2'b10, 1, 0, 4);
    drive(2'b00, 1, 0, 4);
    drive(2'b11, 1, 0, 4);
    check("err_sticky", 32'(err), 32'd1);
    drive(2'b01, 1, 0, 4);
    drive(2'b00, 1, 0, 4);
    drive(2'b00, 1, 1, 1);
    check("err_cleared", 32'(err), 32'd0);
    drive(2'b00, 1, 0, SETTLE + 2);
`ifdef QUAD_FILTER_EN
    // Short pulse is swallowed, long pulse counts once
    drive(2'b10, 1, 0, FILT_LEN - 1);
    drive(2'b00, 1, 0, 8);
    drive(2'b10, 1, 0, FILT_LEN + 4);
`endif
    // Random walk with occasional illegal jumps, enable drops and resets
    g = order_of({quad_a, quad_b});
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 8)       g = (g + 1) % 4;
      else if (r < 16) g = (g + 3) % 4;
      else if (r < 17) g = (g + 2) % 4;
      drive(up_order[g], ($urandom_range(0, 9) < 8), ($urandom_range(0, 199) == 0),
            int'($urandom_range(1, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
